thor2021_btb_updq: RTL
======================

THOR2021_BTB_UPDQ -- requirements
Module: Thor2021_btb_updq

Interface
REQ-001 SHALL have parameter DEPTH, default 8, queue entries; power of two, 2..64.
REQ-002 SHALL have parameter DCW, default 16, drop-counter width.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-low (low at a clk edge resets).
REQ-005 SHALL have port br_v  in  1  resolved-branch update offered this cycle.
REQ-006 SHALL have port br_ip  in  Address (64)  branch instruction address.
REQ-007 SHALL have port br_tgt  in  Address (64)  resolved target.
REQ-008 SHALL have port br_takb  in  1  resolved taken flag.
REQ-009 SHALL have port btb_stall  in  1  BTB write port unavailable this cycle.
REQ-010 SHALL have port br_rdy  out  1  queue not full (count<DEPTH), combinational from count.
REQ-011 SHALL have port wr  out  1  BTB write strobe, registered.
REQ-012 SHALL have port wip  out  Address (64)  BTB write instruction address, registered.
REQ-013 SHALL have port wtgt  out  Address (64)  BTB write target, registered.
REQ-014 SHALL have port takb  out  1  BTB write valid/taken, registered.
REQ-015 SHALL have port count  out  $clog2(DEPTH)+1  entries held.
REQ-016 SHALL have port drop_cnt  out  DCW  updates discarded, saturating.

Function
REQ-017 SHALL store entries {ip,tgt,takb} in a circular buffer with head/tail pointers wrapping modulo DEPTH.
REQ-018 Pop: at each edge with btb_stall=0 and count>0, SHALL load head entry into wip/wtgt/takb, set wr=1, advance head.
REQ-019 At an edge with btb_stall=1 or count=0, SHALL set wr=0 and hold wip/wtgt/takb.
REQ-020 wr SHALL be high for exactly one cycle per popped entry; at most one pop per cycle.
REQ-021 Coalesce: br_v=1, count>0, br_ip equals newest entry (tail-1) ip, and that entry not popped this edge -> SHALL overwrite its tgt/takb; count unchanged.
REQ-022 Coalesce SHALL apply even when full (no drop).
REQ-023 If newest entry is popped same edge (count=1, pop), matching br_ip SHALL allocate a new slot instead.
REQ-024 Push: br_v=1, not coalesced, count<DEPTH -> SHALL write at tail, advance tail.
REQ-025 br_v=1, not coalesced, count=DEPTH -> SHALL discard update and increment drop_cnt, even if a pop occurs same edge.
REQ-026 drop_cnt SHALL saturate at 2^DCW-1.
REQ-027 Simultaneous push and pop SHALL leave count unchanged; push-only +1; pop-only -1.
REQ-028 Latency: update pushed into empty queue at edge E SHALL produce wr=1 in cycle after edge E+1 (2 edges), absent stall.
REQ-029 Entries SHALL leave in arrival order; coalescing does not reorder.
REQ-030 No combinational path from br_v/br_ip/btb_stall to any output except none; br_rdy depends on count only.

Reset
REQ-031 rst=0 at an edge SHALL clear head, tail, count, drop_cnt, wr, takb, wip, wtgt to 0, overriding any push/pop that edge.
REQ-032 Reset mid-operation SHALL discard all queued entries and any pending write; after reset br_rdy=1.

Verification
REQ-033 Reset then single update br_ip=0x1000, br_tgt=0x2000, takb=1, btb_stall=0 -> wr=1 two edges later with wip=0x1000, wtgt=0x2000, takb=1; then wr=0, count=0.
REQ-034 Hold btb_stall=1, push 8 distinct ips 0x10..0x80 -> count=8, br_rdy=0; 9th distinct ip -> drop_cnt=1; release stall -> 8 consecutive wr pulses in push order.
REQ-035 btb_stall=1, push ip 0x40 tgt 0x100, then ip 0x40 tgt 0x200 takb=0 -> count=1; release -> single wr with wtgt=0x200, takb=0.
REQ-036 Full queue, stall released, same-edge non-matching push -> pop occurs, push dropped, count=7, drop_cnt+1; with matching newest ip -> coalesced, no drop.
REQ-037 Wrap: stream 20 updates with alternating btb_stall -> all 20 written in order, pointers wrap, no drops while count<8.
REQ-038 Assert rst=0 with count=5 and wr=1 -> next cycle wr=0, count=0, drop_cnt=0, br_rdy=1.

Source files
------------

// File: rtl/thor2021_btb_updq_if.sv
// Update-queue bus for the BTB: resolved-branch updates in, BTB write port out.
interface thor2021_btb_updq_if #(
    parameter int DEPTH = 8,
    parameter int DCW   = 16
);
    logic                     br_v;
    logic [63:0]              br_ip;
    logic [63:0]              br_tgt;
    logic                     br_takb;
    logic                     btb_stall;
    logic                     br_rdy;
    logic                     wr;
    logic [63:0]              wip;
    logic [63:0]              wtgt;
    logic                     takb;
    logic [$clog2(DEPTH):0]   count;
    logic [DCW-1:0]           drop_cnt;

    modport master (
        output br_v, br_ip, br_tgt, br_takb, btb_stall,
        input  br_rdy, wr, wip, wtgt, takb, count, drop_cnt
    );

    modport slave (
        input  br_v, br_ip, br_tgt, br_takb, btb_stall,
        output br_rdy, wr, wip, wtgt, takb, count, drop_cnt
    );
endinterface

// File: rtl/thor2021_btb_updq.sv
// Circular queue of resolved-branch updates feeding the BTB write port,
// coalescing repeat updates to the newest entry and counting dropped ones.
module thor2021_btb_updq #(
    parameter int DEPTH = 8,
    parameter int DCW   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    thor2021_btb_updq_if.slave   u
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [63:0]    ip_mem   [DEPTH];
    logic [63:0]    tgt_mem  [DEPTH];
    logic           takb_mem [DEPTH];

    logic [PW-1:0]  head_q, head_d, tail_q, tail_d, newest;
    logic [CW-1:0]  count_q, count_d;
    logic [DCW-1:0] drop_q, drop_d;
    logic           wr_q, wr_d, takb_q, takb_d;
    logic [63:0]    wip_q, wip_d, wtgt_q, wtgt_d;
    logic           nonempty, full, pop, coal, push, drop;

    always_comb begin
        nonempty = (count_q != '0);
        full     = (count_q == CW'(DEPTH));
        newest   = tail_q - PW'(1);
        pop      = !u.btb_stall && nonempty;
        // The newest entry cannot absorb an update on the edge it leaves the queue.
        coal     = u.br_v && nonempty && (ip_mem[newest] == u.br_ip)
                   && !(pop && (count_q == CW'(1)));
        push     = u.br_v && !coal && !full;
        drop     = u.br_v && !coal && full;

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        drop_d  = drop_q;
        wr_d    = 1'b0;
        wip_d   = wip_q;
        wtgt_d  = wtgt_q;
        takb_d  = takb_q;

        if (pop) begin
            wr_d   = 1'b1;
            wip_d  = ip_mem[head_q];
            wtgt_d = tgt_mem[head_q];
            takb_d = takb_mem[head_q];
            head_d = head_q + PW'(1);
        end
        if (push) begin
            tail_d = tail_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        if (drop && (drop_q != '1)) begin
            drop_d = drop_q + DCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
            wr_q    <= 1'b0;
            takb_q  <= 1'b0;
            wip_q   <= '0;
            wtgt_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            drop_q  <= drop_d;
            wr_q    <= wr_d;
            takb_q  <= takb_d;
            wip_q   <= wip_d;
            wtgt_q  <= wtgt_d;
        end
    end

    // Entry storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            ip_mem[tail_q]   <= u.br_ip;
            tgt_mem[tail_q]  <= u.br_tgt;
            takb_mem[tail_q] <= u.br_takb;
        end else if (rst && coal) begin
            tgt_mem[newest]  <= u.br_tgt;
            takb_mem[newest] <= u.br_takb;
        end
    end

    assign u.br_rdy   = (count_q < CW'(DEPTH));
    assign u.wr       = wr_q;
    assign u.wip      = wip_q;
    assign u.wtgt     = wtgt_q;
    assign u.takb     = takb_q;
    assign u.count    = count_q;
    assign u.drop_cnt = drop_q;
endmodule
